// File: rtl/gf3_ram_pkg.sv
// gf3_ram_pkg
// Shared definitions for the GF(3^m) RAM command executor.
//   - Opcode codes (OP_*)
//   - Trit codes (T0/T1/T2)
//   - FSM state encoding
//   - Default RAM geometry
//   - Single-trit add/sub helper used by the vector add/sub unit
package gf3_ram_pkg;

    localparam int WIDTH_DEF  = 198;
    localparam int ADDR_W_DEF = 7;

    localparam logic [1:0] OP_COPY = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_OPER,
        ST_MUL_WAIT,
        ST_WRITE
    } state_e;

    // (x +/- y) mod 3 on one trit.
    // The unused code 11 is read as 0, so 11 never reaches the output.
    function automatic logic [1:0] trit_addsub(input logic [1:0] x,
                                               input logic [1:0] y,
                                               input logic       sub);
        logic [1:0] xs;
        logic [1:0] ys;
        logic [1:0] yn;
        logic [2:0] s;
        xs = (x == 2'b11) ? T0 : x;
        ys = (y == 2'b11) ? T0 : y;
        // Subtraction adds the additive inverse: -1 = 2, -2 = 1 (mod 3).
        if (sub)
            yn = (ys == T1) ? T2 : ((ys == T2) ? T1 : T0);
        else
            yn = ys;
        s = {1'b0, xs} + {1'b0, yn};
        if (s >= 3'd3)
            s = s - 3'd3;
        return s[1:0];
    endfunction

endpackage

// File: rtl/gf3_vec_addsub.sv
// gf3_vec_addsub
// Combinational trit-wise add/subtract of two packed GF(3) vectors.
//   - Each WIDTH/2-trit slot is handled independently.
//   - x   [WIDTH] : minuend / first addend
//   - y   [WIDTH] : subtrahend / second addend
//   - sub [1]     : 1 selects x - y, 0 selects x + y
//   - z   [WIDTH] : result; never contains code 11
module gf3_vec_addsub
    import gf3_ram_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] z
);

    for (genvar i = 0; i < WIDTH / 2; i++) begin : g_trit
        assign z[2*i+1:2*i] = trit_addsub(x[2*i+1:2*i], y[2*i+1:2*i], sub);
    end

endmodule

// File: rtl/gf3_ram_exec.sv
// gf3_ram_exec
// Command executor in front of the dual-port operand RAM.
//
// Each command:
//   - reads src1 on port a and src2 on port b;
//   - computes COPY/ADD/SUB locally, or runs MUL on the external multiplier;
//   - writes the result to dst through port a.
//
// Command interface:
//   cmd_valid/cmd_ready, cmd_op, cmd_src1, cmd_src2, cmd_dst.
//   done pulses for one cycle after the result write.
//
// RAM interface:
//   a_wr, a_addr, a_din, a_dout (read and write port);
//   b_wr (tied low), b_addr, b_dout (read-only port).
//   Reads are registered: data is valid the cycle after the address edge.
//
// Multiplier interface:
//   mul_start pulse; mul_a/mul_b held until mul_done; mul_c sampled on mul_done.
module gf3_ram_exec
    import gf3_ram_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic              done,
    output logic              a_wr,
    output logic [ADDR_W-1:0] a_addr,
    output logic [WIDTH-1:0]  a_din,
    input  logic [WIDTH-1:0]  a_dout,
    output logic              b_wr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_dout,
    output logic              mul_start,
    output logic [WIDTH-1:0]  mul_a,
    output logic [WIDTH-1:0]  mul_b,
    input  logic              mul_done,
    input  logic [WIDTH-1:0]  mul_c
);

    state_e            state_q,     state_d;
    logic [1:0]        op_q,        op_d;
    logic [ADDR_W-1:0] dst_q,       dst_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              done_q,      done_d;
    logic              a_wr_q,      a_wr_d;
    logic [ADDR_W-1:0] a_addr_q,    a_addr_d;
    logic [WIDTH-1:0]  a_din_q,     a_din_d;
    logic [ADDR_W-1:0] b_addr_q,    b_addr_d;
    logic              mul_start_q, mul_start_d;
    logic [WIDTH-1:0]  mul_a_q,     mul_a_d;
    logic [WIDTH-1:0]  mul_b_q,     mul_b_d;

    logic [WIDTH-1:0]  alu_y;
    logic [WIDTH-1:0]  alu_z;

    // COPY is computed as x + 0. This yields a_dout for any well-formed word
    // and still normalises stray 11 codes.
    assign alu_y = (op_q == OP_COPY) ? '0 : b_dout;

    gf3_vec_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x   (a_dout),
        .y   (alu_y),
        .sub (op_q == OP_SUB),
        .z   (alu_z)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        cmd_ready_d = cmd_ready_q;
        done_d      = 1'b0;
        a_wr_d      = 1'b0;
        a_addr_d    = a_addr_q;
        a_din_d     = a_din_q;
        b_addr_d    = b_addr_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    dst_d       = cmd_dst;
                    a_addr_d    = cmd_src1;
                    b_addr_d    = cmd_src2;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_READ;
                end
            end
            // RAM registers the read addresses during this cycle.
            ST_READ: state_d = ST_OPER;
            ST_OPER: begin
                if (op_q == OP_MUL) begin
                    mul_a_d     = a_dout;
                    mul_b_d     = b_dout;
                    mul_start_d = 1'b1;
                    state_d     = ST_MUL_WAIT;
                end else begin
                    a_wr_d   = 1'b1;
                    a_addr_d = dst_q;
                    a_din_d  = alu_z;
                    state_d  = ST_WRITE;
                end
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    a_wr_d   = 1'b1;
                    a_addr_d = dst_q;
                    a_din_d  = mul_c;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                done_d      = 1'b1;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_COPY;
            dst_q       <= '0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            a_wr_q      <= 1'b0;
            a_addr_q    <= '0;
            a_din_q     <= '0;
            b_addr_q    <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            a_wr_q      <= a_wr_d;
            a_addr_q    <= a_addr_d;
            a_din_q     <= a_din_d;
            b_addr_q    <= b_addr_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign a_wr      = a_wr_q;
    assign a_addr    = a_addr_q;
    assign a_din     = a_din_q;
    assign b_wr      = 1'b0;
    assign b_addr    = b_addr_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_gf3_ram_exec.sv
// tb_gf3_ram_exec
// Directed bench for gf3_ram_exec.
//   - The operand RAM is modelled behaviourally, with registered reads.
//   - The multiplier is driven by hand from the stimulus block.
module tb_gf3_ram_exec;
    import gf3_ram_pkg::*;

    localparam int W  = 198;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_src1 = '0;
    logic [AW-1:0] cmd_src2 = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic          done;
    logic          a_wr;
    logic [AW-1:0] a_addr;
    logic [W-1:0]  a_din;
    logic [W-1:0]  a_dout;
    logic          b_wr;
    logic [AW-1:0] b_addr;
    logic [W-1:0]  b_dout;
    logic          mul_start;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_done = 1'b0;
    logic [W-1:0]  mul_c = '0;

    logic [W-1:0]  mem [0:127];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [W-1:0]  ld_data = '0;

    int checks = 0;
    int errors = 0;
    int bad;
    int n;

    always #5 clk = ~clk;

    gf3_ram_exec #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src1  (cmd_src1),
        .cmd_src2  (cmd_src2),
        .cmd_dst   (cmd_dst),
        .done      (done),
        .a_wr      (a_wr),
        .a_addr    (a_addr),
        .a_din     (a_din),
        .a_dout    (a_dout),
        .b_wr      (b_wr),
        .b_addr    (b_addr),
        .b_dout    (b_dout),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_c     (mul_c)
    );

    // Dual-port RAM: registered reads, write through port a (or the preload port).
    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (a_wr)
            mem[a_addr] <= a_din;
        a_dout <= mem[a_addr];
        b_dout <= mem[b_addr];
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] ad, input logic [W-1:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_addr = ad;
        ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Called on a negedge while the DUT is idle; returns on the negedge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic [AW-1:0] d);
        cmd_op = op;
        cmd_src1 = s1;
        cmd_src2 = s2;
        cmd_dst = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] top2;
        logic [W-1:0] top1;
        ones = '1;
        top2 = '0;
        top2[W-1:W-2] = 2'b10;
        top1 = '0;
        top1[W-1:W-2] = 2'b01;

        // Reset state
        @(negedge clk);
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst a_wr", a_wr, 0);
        chk("rst done", done, 0);
        chk("rst mul_start", mul_start, 0);
        chk("rst a_addr", a_addr, 0);
        chk("rst a_din", a_din, 0);
        chk("rst b_wr", b_wr, 0);

        load(1, 'h9);
        load(2, 'h6);
        load(3, 'h15);
        load(4, '0);
        load(5, '0);
        load(6, 'h2A);
        load(7, 'h2A);
        load(8, ones);
        load(9, '0);
        load(10, 'h123);
        load(12, '0);
        load(13, top2);
        load(14, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 1,2 -> 3 with cycle-exact timing
        issue(OP_ADD, 1, 2, 3);
        chk("add E0 cmd_ready", cmd_ready, 0);
        chk("add E0 a_wr", a_wr, 0);
        @(negedge clk);
        chk("add E1 a_wr", a_wr, 0);
        @(negedge clk);
        chk("add E2 a_wr", a_wr, 1);
        chk("add E2 a_addr", a_addr, 3);
        chk("add E2 a_din", a_din, 0);
        @(negedge clk);
        chk("add E3 done", done, 1);
        chk("add E3 a_wr", a_wr, 0);
        chk("add E3 cmd_ready", cmd_ready, 1);
        chk("add mem3", mem[3], 0);
        @(negedge clk);
        chk("add done pulse", done, 0);

        // SUB and wrap-around patterns
        issue(OP_SUB, 1, 2, 4);
        wait_done("sub12 done");
        chk("sub12 mem4", mem[4], 'h6);
        issue(OP_SUB, 2, 1, 5);
        wait_done("sub21 done");
        chk("sub21 mem5", mem[5], 'h9);
        issue(OP_SUB, 1, 8, 9);
        wait_done("sub11 done");
        chk("sub all11 mem9", mem[9], 'h9);
        issue(OP_ADD, 2, 2, 12);
        wait_done("add22 done");
        chk("add22 mem12", mem[12], 'h9);
        issue(OP_ADD, 13, 13, 14);
        wait_done("addtop done");
        chk("add top trit mem14", mem[14], top1);

        // MUL handshake
        issue(OP_MUL, 1, 2, 6);
        n = 0;
        while (mul_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mul start", mul_start, 1);
        chk("mul_a", mul_a, 'h9);
        chk("mul_b", mul_b, 'h6);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || a_wr !== 1'b0 || mul_start !== 1'b0 || mul_a !== 'h9)
                bad++;
        end
        chk("mul wait quiet", bad, 0);
        mul_done = 1'b1;
        mul_c = 'h5;
        @(negedge clk);
        mul_done = 1'b0;
        mul_c = '0;
        chk("mul a_wr", a_wr, 1);
        chk("mul a_addr", a_addr, 6);
        chk("mul a_din", a_din, 'h5);
        chk("mul cmd_ready", cmd_ready, 0);
        @(negedge clk);
        chk("mul done", done, 1);
        chk("mul mem6", mem[6], 'h5);

        // Back-to-back with dst/src hazard: ADD 1,2->1 then COPY 1->7
        cmd_op = OP_ADD;
        cmd_src1 = 1;
        cmd_src2 = 2;
        cmd_dst = 1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_op = OP_COPY;
        cmd_src1 = 1;
        cmd_src2 = 5;
        cmd_dst = 7;
        bad = 0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (cmd_ready !== 1'b0 || b_addr !== 2)
                bad++;
            @(negedge clk);
            n++;
        end
        chk("b2b first done", done, 1);
        chk("b2b held off", bad, 0);
        chk("b2b mem1", mem[1], 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b second accepted", cmd_ready, 0);
        chk("b2b second b_addr", b_addr, 5);
        wait_done("b2b copy done");
        chk("b2b mem7", mem[7], 0);

        // Stray mul_done in IDLE
        @(negedge clk);
        mul_done = 1'b1;
        mul_c = 'h3F;
        @(negedge clk);
        mul_done = 1'b0;
        bad = 0;
        repeat (5) begin
            if (a_wr !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || mul_start !== 1'b0)
                bad++;
            @(negedge clk);
        end
        chk("stray mul_done", bad, 0);

        // Reset during MUL_WAIT
        issue(OP_MUL, 2, 12, 10);
        n = 0;
        while (mul_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rmul mul_a", mul_a, 'h6);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmul cmd_ready", cmd_ready, 1);
        chk("rmul mul_a clr", mul_a, 0);
        chk("rmul a_addr clr", a_addr, 0);
        chk("rmul b_addr clr", b_addr, 0);
        chk("rmul a_wr", a_wr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mul_done = 1'b1;
        mul_c = 'h5;
        @(negedge clk);
        mul_done = 1'b0;
        bad = 0;
        repeat (6) begin
            if (a_wr !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
                bad++;
            @(negedge clk);
        end
        chk("rmul late mul_done", bad, 0);
        chk("rmul mem10", mem[10], 'h123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf3_ram_exec.md
Name: gf3_ram_exec

Overview:
- Command executor sitting directly in front of the dual-port operand `ram` (7-bit address, 198-bit words, each word one GF(3^97) element).
- Per command it:
  - reads two operands through RAM ports a and b;
  - computes COPY/ADD/SUB locally, or hands MUL to the external GF(3^m) multiplier over a start/done handshake;
  - writes the result back through RAM port a.
- It is the sole driver of the RAM's address, data and write-enable inputs.

Parameters:
- WIDTH, 198, RAM word width; 2 bits per trit, so WIDTH/2 = 99 trit slots (97 used; the upper slots are carried like any others).
- ADDR_W, 7, RAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_op  in  2  00 COPY, 01 ADD, 10 SUB, 11 MUL.
- cmd_src1  in  ADDR_W  first operand address (read on port a).
- cmd_src2  in  ADDR_W  second operand address (read on port b; ignored by COPY).
- cmd_dst  in  ADDR_W  result address.
- done  out  1  one-cycle pulse after the result write completes.
- a_wr  out  1  RAM port a write enable.
- a_addr  out  ADDR_W  RAM port a address.
- a_din  out  WIDTH  RAM port a write data.
- a_dout  in  WIDTH  RAM port a read data; valid the cycle after the address edge.
- b_wr  out  1  RAM port b write enable; constant 0.
- b_addr  out  ADDR_W  RAM port b address.
- b_dout  in  WIDTH  RAM port b read data.
- mul_start  out  1  one-cycle multiplier start pulse.
- mul_a  out  WIDTH  multiplier operand a (held stable until mul_done).
- mul_b  out  WIDTH  multiplier operand b (held stable until mul_done).
- mul_done  in  1  multiplier result valid, single-cycle pulse.
- mul_c  in  WIDTH  multiplier result, sampled when mul_done is high.

Behaviour:
- Reset (async, rst_n low):
  - state IDLE;
  - all outputs 0 except cmd_ready = 1;
  - internal result/command registers cleared.
- Reset during any state aborts the command: no RAM write occurs and no done pulse is issued.
- All outputs are registered.
- Trit encoding: trit i = bits [2i+1:2i]; 00=0, 01=1, 10=2. Input code 11 is treated as 0. Code 11 is never produced.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/src1/src2/dst, set a_addr=src1, b_addr=src2, cmd_ready<=0, go to READ.
  - READ: wait one cycle for the RAM registered read. Go to OPER.
  - OPER: a_dout/b_dout are valid this cycle.
    - COPY: result = a_dout.
    - ADD: result = trit-wise (x+y) mod 3.
    - SUB: result = trit-wise (x−y) mod 3 (x from port a).
    - COPY/ADD/SUB all go to WRITE, driving a_wr=1, a_addr=dst, a_din=result.
    - MUL: latch mul_a=a_dout, mul_b=b_dout, pulse mul_start, go to MUL_WAIT.
  - MUL_WAIT: on mul_done, result = mul_c, go to WRITE with the same drives as above. There is no timeout; the block waits indefinitely.
  - WRITE: a_wr high for exactly one cycle. The RAM writes at the closing edge. At that edge: a_wr<=0, done<=1, cmd_ready<=1, go to IDLE.
- Latency (acceptance edge E0): the RAM write happens at E3 and done is high in the cycle after E3 for COPY/ADD/SUB. For MUL, the write happens 1 edge after the mul_done edge.
- Back-to-back commands:
  - The earliest next acceptance is the edge after done rises (the IDLE cycle).
  - A following command reading the previous dst sees the new value; there is no bypass and none is needed.
- src1 == src2, or dst equal to either source: legal, with no special handling.
- mul_done while not in MUL_WAIT is ignored.
- cmd_valid while not ready is ignored; the command must be held by the source until accepted.
- b_wr is tied to 0; port a is the only write path.

Decomposition:
- Package gf3_ram_pkg holds:
  - opcode localparams OP_COPY, OP_ADD, OP_SUB, OP_MUL;
  - trit codes T0, T1, T2;
  - the state encoding;
  - WIDTH/ADDR_W defaults.
- Sub-module gf3_vec_addsub: combinational, inputs x, y, sub; output z; built from WIDTH/2 per-trit add/sub cells. It is instantiated once in OPER.

Test Plan:
- ADD: mem[1]=0x9 (t0=1, t1=2), mem[2]=0x6 (t0=2, t1=1); cmd ADD 1,2→3. Required: a_wr at the 3rd edge after acceptance with a_addr=3 and a_din=0; done one cycle later; mem[3]=0.
- SUB: same operands, SUB 1,2→4 → mem[4]=0x6. SUB 2,1→5 → mem[5]=0x9. Also check that an all-11 input word is treated as 0: SUB of it from 0x9 gives 0x9.
- MUL handshake: MUL 1,2→6. Required: mul_start is a single pulse with mul_a=0x9 and mul_b=0x6. Model asserts mul_done 10 cycles later with mul_c=0x5. Required: a_wr on the next edge, mem[6]=0x5, cmd_ready low throughout.
- Back-to-back/hazard: ADD 1,2→1 then immediately COPY 1→7. Required: mem[7]=0. The second command is accepted only after the first done; a stray mul_done in IDLE produces no activity.
- Reset mid-op: drop rst_n during MUL_WAIT. Required: outputs 0 immediately, cmd_ready=1; a later mul_done is ignored; the dst location is unchanged.
